// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;

    // Arbiter modes: NORMAL shares the port, REQ asks the pipeline to stall,
    // DRAIN owns the port for one buffered result.
    typedef enum logic [1:0] {
        ARB_NORMAL = 2'b00,
        ARB_REQ    = 2'b01,
        ARB_DRAIN  = 2'b10
    } arb_state_e;

    // One buffered long-latency result.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic [REG_W-1:0]      wdata;
    } aux_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Age-ordered buffer of divider results. Slot 0 is always the oldest live
// entry; every cycle survivors are compacted toward slot 0 after pop and
// address kill, then a new entry is appended behind them.
module wb_aux_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_wd,
    input  logic [REG_W-1:0]      push_wdata,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    output logic [REG_ADDR_W-1:0] head_wd,
    output logic [REG_W-1:0]      head_wdata,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);

    aux_entry_t       mem_q [DEPTH];
    aux_entry_t       mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Keep surviving entries in age order, packed from slot 0, then append the push.
    always_comb begin
        int n;
        // NOTE: every output of this block gets a default before any branch so no latch is inferred.
        n       = 0;
        valid_d = '0;
        for (int j = 0; j < DEPTH; j++) mem_d[j] = mem_q[j];
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !(pop && i == 0) && !(kill && mem_q[i].wd == kill_addr)) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == n) begin
                        mem_d[j]   = mem_q[i];
                        valid_d[j] = 1'b1;
                    end
                end
                n++;
            end
        end
        if (push) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == n) begin
                    mem_d[j]   = '{wd: push_wd, wdata: push_wdata};
                    valid_d[j] = 1'b1;
                end
            end
        end
    end

    // Occupancy bits: cleared by reset, which discards every buffered result.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload slots are deliberately not reset; the valid bits alone decide what is live.
        mem_q <= mem_d;
    end

    // Occupancy count for the pipeline-visible aux_pending.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(valid_q[i]);
    end

    assign head_wd    = mem_q[0].wd;
    assign head_wdata = mem_q[0].wdata;
    assign empty      = !valid_q[0];
    assign full       = valid_q[DEPTH-1];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM/WB stream and the
// divider. The pipeline has priority; divider results wait in a small FIFO
// and, if they wait too long, the arbiter stalls the pipeline to drain one.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int PEND_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [4:0]        wb_wd,
    input  logic [31:0]       wb_wdata,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [4:0]        aux_wd,
    input  logic [31:0]       aux_wdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              stall_req,
    output logic [PEND_W-1:0] aux_pending
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                pipe_req, grant_pipe, pop, push;
    logic                fifo_empty, fifo_full;
    logic [4:0]          head_wd;
    logic [31:0]         head_wdata;

    // Writes to r0 are architectural no-ops, so they never compete for the port.
    assign pipe_req  = wb_wreg && (wb_wd != NOP_REG_ADDR);
    assign aux_ready = rst && !fifo_full;

    // An aux result aimed at r0, or at the register the pipeline overwrites this
    // cycle, is stale on arrival: accept it but do not buffer it.
    assign push = aux_valid && aux_ready && (aux_wd != NOP_REG_ADDR)
               && !(grant_pipe && aux_wd == wb_wd);

    wb_aux_fifo #(.DEPTH(DEPTH), .CNT_W(PEND_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_wd    (aux_wd),
        .push_wdata (aux_wdata),
        .pop        (pop),
        .kill       (grant_pipe),
        .kill_addr  (wb_wd),
        .head_wd    (head_wd),
        .head_wdata (head_wdata),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (aux_pending)
    );

    // Port grant and arbiter next state.
    always_comb begin
        state_d    = state_q;
        grant_pipe = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ARB_NORMAL: begin
                grant_pipe = pipe_req;
                pop        = !pipe_req && !fifo_empty;
                if (starve_q == STARVE_W'(STARVE_LIMIT)) state_d = ARB_REQ;
            end
            ARB_REQ: begin
                // The write already in MEM/WB still completes; the bubble arrives next cycle.
                grant_pipe = pipe_req;
                pop        = !pipe_req && !fifo_empty;
                state_d    = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                // The head may already be gone (popped or killed during REQ); then just resume.
                pop     = !fifo_empty;
                state_d = ARB_NORMAL;
            end
            default: state_d = ARB_NORMAL;
        endcase
    end

    // Count cycles the head waits without the port; saturate rather than wrap.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty)                      starve_d = '0;
        else if (starve_q != STARVE_W'(STARVE_LIMIT)) starve_d = starve_q + STARVE_W'(1);
    end

    // State, starve counter and registered write-port / stall outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_NORMAL;
            starve_q  <= '0;
            stall_req <= 1'b0;
            rf_we     <= WRITE_DISABLE;
            rf_waddr  <= NOP_REG_ADDR;
            rf_wdata  <= ZERO_WORD;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            stall_req <= (state_d != ARB_NORMAL);
            if (grant_pipe) begin
                rf_we    <= WRITE_ENABLE;
                rf_waddr <= wb_wd;
                rf_wdata <= wb_wdata;
            end else if (pop) begin
                rf_we    <= WRITE_ENABLE;
                rf_waddr <= head_wd;
                rf_wdata <= head_wdata;
            end else begin
                rf_we    <= WRITE_DISABLE;
                rf_waddr <= NOP_REG_ADDR;
                rf_wdata <= ZERO_WORD;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed expectations, one
// check() per comparison, single summary line at the end.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_wreg = 1'b0;
    logic [4:0]  wb_wd = '0;
    logic [31:0] wb_wdata = '0;
    logic        aux_valid = 1'b0;
    logic        aux_ready;
    logic [4:0]  aux_wd = '0;
    logic [31:0] aux_wdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [1:0]  aux_pending;

    int n_checks = 0;
    int n_pass   = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_wreg     (wb_wreg),
        .wb_wd       (wb_wd),
        .wb_wdata    (wb_wdata),
        .aux_valid   (aux_valid),
        .aux_ready   (aux_ready),
        .aux_wd      (aux_wd),
        .aux_wdata   (aux_wdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall_req   (stall_req),
        .aux_pending (aux_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] wd, input logic [31:0] d);
        wb_wreg  = we;
        wb_wd    = wd;
        wb_wdata = d;
    endtask

    task automatic aux(input logic v, input logic [4:0] wd, input logic [31:0] d);
        aux_valid = v;
        aux_wd    = wd;
        aux_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst rf_we", rf_we, 0);
        check("rst rf_waddr", rf_waddr, 0);
        check("rst rf_wdata", rf_wdata, 0);
        check("rst stall_req", stall_req, 0);
        check("rst aux_pending", aux_pending, 0);
        check("rst aux_ready", aux_ready, 0);
        rst = 1'b1;
        #1;
        check("post-rst aux_ready", aux_ready, 1);

        // Idle pipeline: aux result written one edge after it is buffered
        tick();
        aux(1, 5, 32'h10);
        tick();
        aux(0, 0, 0);
        check("t2 pending", aux_pending, 1);
        tick();
        check("t2 rf_we", rf_we, 1);
        check("t2 rf_waddr", rf_waddr, 5);
        check("t2 rf_wdata", rf_wdata, 32'h10);
        check("t2 pending drained", aux_pending, 0);
        tick();
        check("t2 idle rf_we", rf_we, 0);

        // Starvation: pipeline writes every cycle, aux r7 waits
        pipe(1, 1, 32'hA1);
        aux(1, 7, 32'h77);
        tick();
        aux(0, 0, 0);
        check("t3 pending", aux_pending, 1);
        check("t3 pipe waddr", rf_waddr, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t3 no stall %0d", k), stall_req, 0);
        end
        tick();
        check("t3 stall rises", stall_req, 1);
        check("t3 pipe still writes", rf_waddr, 1);
        pipe(1, 2, 32'hB2);
        tick();
        check("t3 inflight waddr", rf_waddr, 2);
        check("t3 inflight wdata", rf_wdata, 32'hB2);
        check("t3 stall held", stall_req, 1);
        check("t3 pending held", aux_pending, 1);
        pipe(0, 0, 0);
        tick();
        check("t3 drain rf_we", rf_we, 1);
        check("t3 drain waddr", rf_waddr, 7);
        check("t3 drain wdata", rf_wdata, 32'h77);
        check("t3 stall falls", stall_req, 0);
        check("t3 pending empty", aux_pending, 0);

        // WAW kill of a buffered entry
        pipe(1, 1, 32'h11);
        aux(1, 9, 32'h99);
        tick();
        aux(0, 0, 0);
        check("t4 pending before kill", aux_pending, 1);
        pipe(1, 9, 32'hAAAA);
        tick();
        check("t4 kill waddr", rf_waddr, 9);
        check("t4 kill wdata", rf_wdata, 32'hAAAA);
        check("t4 pending after kill", aux_pending, 0);
        pipe(0, 0, 0);
        tick();
        check("t4 no stale write 1", rf_we, 0);
        tick();
        check("t4 no stale write 2", rf_we, 0);

        // Same-cycle kill of an arriving result, and r0 aux drop
        pipe(1, 4, 32'h44);
        aux(1, 4, 32'hBAD);
        tick();
        check("waw arrive pending", aux_pending, 0);
        check("waw arrive wdata", rf_wdata, 32'h44);
        pipe(0, 0, 0);
        aux(1, 0, 32'h123);
        tick();
        aux(0, 0, 0);
        check("r0 aux pending", aux_pending, 0);
        tick();
        check("r0 aux no write", rf_we, 0);

        // Full FIFO back-pressure and age order
        pipe(1, 1, 32'h1);
        aux(1, 10, 32'hA0);
        tick();
        aux(1, 11, 32'hB0);
        tick();
        aux(1, 12, 32'hC0);
        #1;
        check("t5 full pending", aux_pending, 2);
        check("t5 full ready", aux_ready, 0);
        tick();
        check("t5 held pending", aux_pending, 2);
        check("t5 held ready", aux_ready, 0);
        pipe(0, 0, 0);
        tick();
        check("t5 pop1 waddr", rf_waddr, 10);
        check("t5 no push on pop", aux_pending, 1);
        check("t5 ready again", aux_ready, 1);
        tick();
        aux(0, 0, 0);
        check("t5 pop2 waddr", rf_waddr, 11);
        check("t5 pop2 wdata", rf_wdata, 32'hB0);
        check("t5 push+pop pending", aux_pending, 1);
        tick();
        check("t5 pop3 waddr", rf_waddr, 12);
        check("t5 pop3 wdata", rf_wdata, 32'hC0);
        check("t5 empty", aux_pending, 0);
        check("t5 no stall", stall_req, 0);

        // Pipeline r0 write is not a request
        pipe(1, 1, 32'h5);
        aux(1, 3, 32'h33);
        tick();
        aux(0, 0, 0);
        pipe(1, 0, 32'hDEAD);
        tick();
        check("t6 head waddr", rf_waddr, 3);
        check("t6 head wdata", rf_wdata, 32'h33);
        check("t6 pending", aux_pending, 0);
        pipe(0, 0, 0);
        tick();

        // Reset mid-operation with two entries buffered
        pipe(1, 1, 32'h11);
        aux(1, 13, 32'hD0);
        tick();
        aux(1, 14, 32'hE0);
        tick();
        aux(0, 0, 0);
        check("t1 pending before rst", aux_pending, 2);
        check("t1 rf_we before rst", rf_we, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t1 rst rf_we", rf_we, 0);
        check("t1 rst pending", aux_pending, 0);
        check("t1 rst stall", stall_req, 0);
        check("t1 rst ready", aux_ready, 0);
        pipe(0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t1 no partial write", rf_we, 0);
        check("t1 still empty", aux_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
